sprite_compositor: RTL and testbench
====================================

# sprite_compositor

Owns the per-sprite configuration registers written by the CPU over the picosoc iomem bus and drives them, flattened, to the `NUM_SPRITES` sprite bounding-box/address units. It also consumes those units' hit flags and sprite-memory addresses, selects the highest-priority sprite per pixel, and issues the read to sprite memory. It then emits a registered sprite pixel (palette + colour index, opaque flag) to the video mixer, and keeps sticky sprite-overlap collision flags readable by the CPU.

## Interface
- `NUM_SPRITES`, 8: number of sprite units served; legal values 2..16.
- `clk`  in  1  pixel/system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `iomem_valid`  in  1  CPU bus request; held until `iomem_ready`.
- `iomem_wstrb`  in  4  byte write strobes; all zero means read.
- `iomem_addr`  in  8  byte address; word index is `iomem_addr[7:2]`.
- `iomem_wdata`  in  32  write data.
- `iomem_rdata`  out  32  read data, valid while `iomem_ready` is high.
- `iomem_ready`  out  1  single-cycle completion pulse.
- `frame_start`  in  1  one-cycle pulse at the start of vertical blank.
- `sprite_config`  out  32*NUM_SPRITES  active configuration; sprite i is in bits [32i+31:32i].
- `sprite_hit`  in  NUM_SPRITES  bounding-box hit from each sprite unit.
- `sprite_addr`  in  14*NUM_SPRITES  sprite memory address from each unit.
- `spr_mem_addr`  out  14  registered read address to sprite memory (synchronous-read RAM).
- `spr_mem_data`  in  4  colour index returned by the RAM one cycle after the address is sampled.
- `pix_color`  out  6  {palette[1:0], colour[3:0]}.
- `pix_opaque`  out  1  high when a sprite covers the pixel and colour is non-zero.

## Operation
- Register map (word index):
  - 0..NUM_SPRITES-1: sprite config (R/W; layout fixed by the sprite unit, bit 31 stored but unused).
  - NUM_SPRITES: collision status. Bit i is sticky. Reads return the value and clear it. Writes are ignored.
  - Higher indices: reads return 0, writes are ignored, and `iomem_ready` is still returned.
- Byte strobes apply per byte lane.
- Priority: the lowest index `i` with `sprite_hit[i]` wins. Its `sprite_addr` slice and config bits [27:26] (palette) are selected.
- No hit: address 0 and the hit flag are cleared in the pipeline, so the outputs become transparent.
- Transparency: a colour index of 0 gives `pix_opaque`=0. `pix_color` still outputs the fetched value.
- Collision: if two or more `sprite_hit` bits are high in a cycle, every hitting sprite's status bit is set.
  - A read-clear in the same cycle as a new set leaves that bit set.
- Bus FSM has two states, IDLE and ACK.
  - IDLE: `iomem_valid` moves the FSM to ACK, performing the write or latching read data.
  - ACK: `iomem_ready`=1 for one cycle, then the FSM returns to IDLE. `iomem_valid` seen during ACK is not treated as a new request.

## Timing
- Pixel pipeline is three edges long:
  - E0 registers the selected `spr_mem_addr`, palette and hit.
  - E1: the RAM samples the address.
  - E2 registers `pix_color`/`pix_opaque` from `spr_mem_data` and the delayed palette/hit.
  - Result: the outputs reflect the screen position presented to the sprite units 3 cycles earlier. Throughput is one pixel per clock, with no stalls.
- Bus: `iomem_ready` rises on the cycle after `iomem_valid` is first seen in IDLE. Back-to-back requests therefore complete every 2 cycles.
- A config write becomes visible on `sprite_config` on the edge that completes it, i.e. in the ACK cycle. This is the non-shadow build; see Configuration.
- Reset values: every config register is 0 (all sprites disabled). The following are all 0: collision status, `spr_mem_addr`, `pix_color`, `pix_opaque`, `iomem_ready`, `iomem_rdata`. The FSM resets to IDLE.
- Reset asserted mid-transaction aborts it with no `iomem_ready`. The interrupted write is lost.

## Configuration
- `SPRITE_SHADOW_EN` defined:
  - CPU writes go to a shadow bank.
  - On `frame_start`, all shadow entries are copied to the active bank that drives `sprite_config`.
  - Config reads return shadow contents.
  - A write coinciding with `frame_start`: the commit copies the pre-write shadow value, and the new value commits at the next `frame_start`.
  - Both banks reset to 0.
- `SPRITE_SHADOW_EN` undefined:
  - A single bank is used and writes take effect immediately.
  - `frame_start` is ignored.

## Test plan
- Reset, then read words 0..NUM_SPRITES → all 0; `pix_opaque`=0 and `iomem_ready` pulses once per read.
- Write word 2 = 0x1050_0C20 with strobes 4'b0011, then read → 0x0000_0C20. Write all strobes, then read → 0x1050_0C20.
- `sprite_hit`=8'b0000_0110, sprite 1 addr 0x0123, sprite 2 addr 0x0456 → `spr_mem_addr`=0x0123 one edge later. With `spr_mem_data`=4'h7, `pix_color`={palette of sprite 1, 4'h7} and `pix_opaque`=1 three cycles after the hit. With data=0, `pix_opaque`=0.
- Hits 8'b1000_0001 for one cycle → collision read returns 0x81 and a second read returns 0. A hit during the read cycle leaves the corresponding bit set.
- With `SPRITE_SHADOW_EN`: write word 0 = 0x1000_0000 → `sprite_config[31:0]` is unchanged until the `frame_start` pulse, and changes on the edge after it. A write in the same cycle as `frame_start` commits only at the following pulse.
- Assert `resetn` low during ACK → `iomem_ready` goes to 0 immediately, and the register holds its old (reset) value.

Source files
------------

// File: rtl/sprite_compositor.sv
// sprite_compositor: sprite config registers, priority select, pixel pipe.
// Build option: define SPRITE_SHADOW_EN for frame-synchronous shadow bank.
//
// Ports:
//   clk, resetn                  clock, async active-low reset
//   iomem_valid/wstrb/addr/wdata picosoc iomem request (word = addr[7:2])
//   iomem_rdata/iomem_ready      read data, one-cycle completion pulse
//   frame_start                  vblank pulse (commits shadow bank)
//   sprite_config                active config, sprite i at [32i+31:32i]
//   sprite_hit/sprite_addr       per-unit hit flags and memory addresses
//   spr_mem_addr/spr_mem_data    synchronous-read sprite RAM port
//   pix_color/pix_opaque         registered sprite pixel to the mixer
module sprite_compositor #(
    parameter int NUM_SPRITES = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        iomem_valid,
    input  logic [3:0]                  iomem_wstrb,
    input  logic [7:0]                  iomem_addr,
    input  logic [31:0]                 iomem_wdata,
    output logic [31:0]                 iomem_rdata,
    output logic                        iomem_ready,
    input  logic                        frame_start,
    output logic [32*NUM_SPRITES-1:0]   sprite_config,
    input  logic [NUM_SPRITES-1:0]      sprite_hit,
    input  logic [14*NUM_SPRITES-1:0]   sprite_addr,
    output logic [13:0]                 spr_mem_addr,
    input  logic [3:0]                  spr_mem_data,
    output logic [5:0]                  pix_color,
    output logic                        pix_opaque
);

    typedef enum logic {
        IDLE,
        ACK
    } bus_state_t;

    localparam logic [NUM_SPRITES-1:0] ONE =
        {{(NUM_SPRITES-1){1'b0}}, 1'b1};

    bus_state_t             state;
    logic [5:0]             word;
    logic [31:0]            cfg [NUM_SPRITES];
    logic [31:0]            act [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] coll;
    logic [NUM_SPRITES-1:0] coll_set;
    logic                   bus_req;
    logic                   bus_wr;
    logic                   coll_rd;
    logic [31:0]            rd_word;

    assign word    = iomem_addr[7:2];
    assign bus_req = (state == IDLE) && iomem_valid;
    assign bus_wr  = |iomem_wstrb;
    assign coll_rd = bus_req && !bus_wr &&
                     (word == 6'(NUM_SPRITES));

    // Two or more hits in one cycle: flag every sprite involved.
    assign coll_set = ((sprite_hit & (sprite_hit - ONE)) != '0)
                    ? sprite_hit : '0;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (word == 6'(i)) begin
                rd_word = cfg[i];
            end
        end
        if (word == 6'(NUM_SPRITES)) begin
            rd_word = 32'(coll);
        end
    end

    // Bus FSM; the write lands on the accepting edge so it is
    // visible during the ACK cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            coll        <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                cfg[i] <= '0;
            end
        end else begin
            // Set wins over a coincident read-clear.
            coll <= (coll_rd ? '0 : coll) | coll_set;
            unique case (state)
                IDLE: begin
                    if (iomem_valid) begin
                        state       <= ACK;
                        iomem_ready <= 1'b1;
                        if (bus_wr) begin
                            for (int i = 0; i < NUM_SPRITES; i++) begin
                                if (word == 6'(i)) begin
                                    for (int b = 0; b < 4; b++) begin
                                        if (iomem_wstrb[b]) begin
                                            cfg[i][8*b +: 8] <=
                                                iomem_wdata[8*b +: 8];
                                        end
                                    end
                                end
                            end
                        end else begin
                            iomem_rdata <= rd_word;
                        end
                    end
                end
                ACK: begin
                    state       <= IDLE;
                    iomem_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPRITE_SHADOW_EN
    // Nonblocking copy: a write on the frame_start edge is not
    // seen by this commit and waits for the next one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                act[i] <= '0;
            end
        end else if (frame_start) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                act[i] <= cfg[i];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^iomem_addr[1:0];
`else
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            act[i] = cfg[i];
        end
    end

    logic unused_bits;
    assign unused_bits = ^{iomem_addr[1:0], frame_start};
`endif

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_flat
        assign sprite_config[32*g +: 32] = act[g];
    end

    logic [13:0] sel_addr;
    logic [1:0]  sel_pal;
    logic        sel_hit;

    // Walk high to low so the lowest hitting index is the last write.
    always_comb begin
        sel_addr = '0;
        sel_pal  = '0;
        sel_hit  = 1'b0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (sprite_hit[i]) begin
                sel_addr = sprite_addr[14*i +: 14];
                sel_pal  = act[i][27:26];
                sel_hit  = 1'b1;
            end
        end
    end

    logic [1:0] pal_e0;
    logic [1:0] pal_e1;
    logic       hit_e0;
    logic       hit_e1;

    // E0 address/palette/hit, E1 RAM sample (palette/hit ride
    // alongside), E2 final pixel register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            spr_mem_addr <= '0;
            pal_e0       <= '0;
            hit_e0       <= 1'b0;
            pal_e1       <= '0;
            hit_e1       <= 1'b0;
            pix_color    <= '0;
            pix_opaque   <= 1'b0;
        end else begin
            spr_mem_addr <= sel_addr;
            pal_e0       <= sel_pal;
            hit_e0       <= sel_hit;
            pal_e1       <= pal_e0;
            hit_e1       <= hit_e0;
            pix_color    <= {pal_e1, spr_mem_data};
            pix_opaque   <= hit_e1 && (spr_mem_data != 4'h0);
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed bench for sprite_compositor.
// Covers bus map, strobes, priority pipeline, collisions, resets.
module tb_sprite_compositor;

    localparam int N = 8;
    localparam logic [7:0] COLL_A = 8'h20;

`ifdef SPRITE_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            iomem_valid = 1'b0;
    logic [3:0]      iomem_wstrb = '0;
    logic [7:0]      iomem_addr = '0;
    logic [31:0]     iomem_wdata = '0;
    logic [31:0]     iomem_rdata;
    logic            iomem_ready;
    logic            frame_start = 1'b0;
    logic [32*N-1:0] sprite_config;
    logic [N-1:0]    sprite_hit = '0;
    logic [14*N-1:0] sprite_addr = '0;
    logic [13:0]     spr_mem_addr;
    logic [3:0]      spr_mem_data;
    logic [5:0]      pix_color;
    logic            pix_opaque;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rd;
    int          cyc;

    always #5 clk = ~clk;

    sprite_compositor #(.NUM_SPRITES(N)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .iomem_valid  (iomem_valid),
        .iomem_wstrb  (iomem_wstrb),
        .iomem_addr   (iomem_addr),
        .iomem_wdata  (iomem_wdata),
        .iomem_rdata  (iomem_rdata),
        .iomem_ready  (iomem_ready),
        .frame_start  (frame_start),
        .sprite_config(sprite_config),
        .sprite_hit   (sprite_hit),
        .sprite_addr  (sprite_addr),
        .spr_mem_addr (spr_mem_addr),
        .spr_mem_data (spr_mem_data),
        .pix_color    (pix_color),
        .pix_opaque   (pix_opaque)
    );

    // Sprite RAM contents used by the pixel scenarios.
    function automatic logic [3:0] ram_f(input logic [13:0] a);
        if (a == 14'h0123) return 4'h7;
        if (a == 14'h0456) return 4'h9;
        return 4'h0;
    endfunction

    always @(posedge clk) spr_mem_data <= ram_f(spr_mem_addr);

    // Bounded bus transfer; cyc = edges until iomem_ready (8 = timeout).
    task automatic bus_xfer(input logic [7:0] a, input logic [3:0] s,
                            input logic [31:0] wd,
                            output logic [31:0] rdo, output int c);
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = wd;
        iomem_valid = 1'b1;
        c = 0;
        do begin
            @(posedge clk); #1;
            c++;
        end while (!iomem_ready && c < 8);
        rdo = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({iomem_ready, iomem_rdata} !== 33'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got %b/%h exp 0/0",
                     iomem_ready, iomem_rdata);
        end
        n_tests++;
        if ({spr_mem_addr, pix_color, pix_opaque} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_pix: addr %h col %h op %b exp 0",
                     spr_mem_addr, pix_color, pix_opaque);
        end
        n_tests++;
        if (sprite_config !== '0) begin
            n_fail++;
            $display("FAIL reset_cfg: got %h exp 0", sprite_config);
        end
        for (int w = 0; w <= N; w++) begin
            bus_xfer(8'(w * 4), 4'h0, 32'h0, rd, cyc);
            n_tests++;
            if (rd !== 32'h0 || cyc !== 1 || iomem_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_rd w%0d: got %h cyc %0d rdy %b exp 0 1 0",
                         w, rd, cyc, iomem_ready);
            end
        end
    endtask

    task automatic test_byte_strobes();
        bus_xfer(8'h08, 4'b0011, 32'h1050_0C20, rd, cyc);
        bus_xfer(8'h08, 4'h0, 32'h0, rd, cyc);
        n_tests++;
        if (rd !== 32'h0000_0C20) begin
            n_fail++;
            $display("FAIL strobe_lo: got %h exp 00000c20", rd);
        end
        bus_xfer(8'h08, 4'b1100, 32'hAABB_CCDD, rd, cyc);
        bus_xfer(8'h08, 4'h0, 32'h0, rd, cyc);
        n_tests++;
        if (rd !== 32'hAABB_0C20) begin
            n_fail++;
            $display("FAIL strobe_hi: got %h exp aabb0c20", rd);
        end
        bus_xfer(8'h08, 4'hF, 32'h1050_0C20, rd, cyc);
        bus_xfer(8'h08, 4'h0, 32'h0, rd, cyc);
        n_tests++;
        if (rd !== 32'h1050_0C20) begin
            n_fail++;
            $display("FAIL strobe_all: got %h exp 10500c20", rd);
        end
    endtask

    task automatic test_out_of_range();
        bus_xfer(8'h24, 4'hF, 32'hFFFF_FFFF, rd, cyc);
        n_tests++;
        if (cyc !== 1) begin
            n_fail++;
            $display("FAIL oor_wr_ready: got cyc %0d exp 1", cyc);
        end
        bus_xfer(8'h24, 4'h0, 32'h0, rd, cyc);
        n_tests++;
        if (rd !== 32'h0 || cyc !== 1) begin
            n_fail++;
            $display("FAIL oor_rd9: got %h cyc %0d exp 0 1", rd, cyc);
        end
        bus_xfer(8'hFC, 4'h0, 32'h0, rd, cyc);
        n_tests++;
        if (rd !== 32'h0 || cyc !== 1) begin
            n_fail++;
            $display("FAIL oor_rd63: got %h cyc %0d exp 0 1", rd, cyc);
        end
        bus_xfer(COLL_A, 4'hF, 32'hFFFF_FFFF, rd, cyc);
        bus_xfer(COLL_A, 4'h0, 32'h0, rd, cyc);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL coll_wr_ignored: got %h exp 0", rd);
        end
    endtask

    task automatic test_config_commit();
        logic [31:0] exp;
        iomem_addr  = 8'h00;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h1000_0000;
        iomem_valid = 1'b1;
        @(posedge clk); #1;
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        exp = SHADOW ? 32'h0 : 32'h1000_0000;
        n_tests++;
        if (iomem_ready !== 1'b1 || sprite_config[31:0] !== exp) begin
            n_fail++;
            $display("FAIL cfg_ack: rdy %b cfg %h exp 1 %h",
                     iomem_ready, sprite_config[31:0], exp);
        end
        @(posedge clk); #1;
        bus_xfer(8'h00, 4'h0, 32'h0, rd, cyc);
        n_tests++;
        if (rd !== 32'h1000_0000) begin
            n_fail++;
            $display("FAIL cfg_readback: got %h exp 10000000", rd);
        end
        pulse_frame();
        n_tests++;
        if (sprite_config[31:0] !== 32'h1000_0000) begin
            n_fail++;
            $display("FAIL cfg_commit1: got %h exp 10000000",
                     sprite_config[31:0]);
        end
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h2000_0000;
        iomem_valid = 1'b1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        frame_start = 1'b0;
        exp = SHADOW ? 32'h1000_0000 : 32'h2000_0000;
        n_tests++;
        if (sprite_config[31:0] !== exp) begin
            n_fail++;
            $display("FAIL cfg_coincide: got %h exp %h",
                     sprite_config[31:0], exp);
        end
        @(posedge clk); #1;
        pulse_frame();
        n_tests++;
        if (sprite_config[31:0] !== 32'h2000_0000) begin
            n_fail++;
            $display("FAIL cfg_commit2: got %h exp 20000000",
                     sprite_config[31:0]);
        end
    endtask

    task automatic test_pixel_pipeline();
        bus_xfer(8'h04, 4'hF, 32'h0800_0000, rd, cyc);
        bus_xfer(8'h08, 4'hF, 32'h0400_0000, rd, cyc);
        pulse_frame();
        sprite_addr[14*1 +: 14] = 14'h0123;
        sprite_addr[14*2 +: 14] = 14'h0456;
        sprite_hit = 8'b0000_0110;
        @(posedge clk); #1;
        n_tests++;
        if (spr_mem_addr !== 14'h0123) begin
            n_fail++;
            $display("FAIL pix_addr0: got %h exp 0123", spr_mem_addr);
        end
        sprite_hit = 8'b0000_0100;
        @(posedge clk); #1;
        n_tests++;
        if (spr_mem_addr !== 14'h0456 || pix_opaque !== 1'b0) begin
            n_fail++;
            $display("FAIL pix_addr1: got %h op %b exp 0456 0",
                     spr_mem_addr, pix_opaque);
        end
        sprite_hit = '0;
        @(posedge clk); #1;
        n_tests++;
        if (pix_color !== 6'h27 || pix_opaque !== 1'b1 ||
            spr_mem_addr !== 14'h0) begin
            n_fail++;
            $display("FAIL pix_first: col %h op %b addr %h exp 27 1 0",
                     pix_color, pix_opaque, spr_mem_addr);
        end
        sprite_addr[14*1 +: 14] = 14'h0200;
        sprite_hit = 8'b0000_0010;
        @(posedge clk); #1;
        sprite_hit = '0;
        n_tests++;
        if (pix_color !== 6'h19 || pix_opaque !== 1'b1) begin
            n_fail++;
            $display("FAIL pix_second: col %h op %b exp 19 1",
                     pix_color, pix_opaque);
        end
        @(posedge clk); #1;
        n_tests++;
        if (pix_color !== 6'h00 || pix_opaque !== 1'b0) begin
            n_fail++;
            $display("FAIL pix_nohit: col %h op %b exp 00 0",
                     pix_color, pix_opaque);
        end
        @(posedge clk); #1;
        n_tests++;
        if (pix_color !== 6'h20 || pix_opaque !== 1'b0) begin
            n_fail++;
            $display("FAIL pix_transp: col %h op %b exp 20 0",
                     pix_color, pix_opaque);
        end
    endtask

    task automatic test_collision();
        bus_xfer(COLL_A, 4'h0, 32'h0, rd, cyc);
        n_tests++;
        if (rd !== 32'h06) begin
            n_fail++;
            $display("FAIL coll_prior: got %h exp 06", rd);
        end
        sprite_hit = 8'b1000_0001;
        @(posedge clk); #1;
        sprite_hit = '0;
        bus_xfer(COLL_A, 4'h0, 32'h0, rd, cyc);
        n_tests++;
        if (rd !== 32'h81) begin
            n_fail++;
            $display("FAIL coll_set: got %h exp 81", rd);
        end
        bus_xfer(COLL_A, 4'h0, 32'h0, rd, cyc);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL coll_clear: got %h exp 0", rd);
        end
        sprite_hit  = 8'b0000_0011;
        iomem_addr  = COLL_A;
        iomem_wstrb = 4'h0;
        iomem_valid = 1'b1;
        @(posedge clk); #1;
        sprite_hit  = '0;
        iomem_valid = 1'b0;
        n_tests++;
        if (iomem_ready !== 1'b1 || iomem_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL coll_race_rd: rdy %b got %h exp 1 0",
                     iomem_ready, iomem_rdata);
        end
        @(posedge clk); #1;
        bus_xfer(COLL_A, 4'h0, 32'h0, rd, cyc);
        n_tests++;
        if (rd !== 32'h03) begin
            n_fail++;
            $display("FAIL coll_race_kept: got %h exp 03", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] rdy;
        logic       data_ok;
        data_ok = 1'b1;
        iomem_addr  = 8'h08;
        iomem_wstrb = 4'h0;
        iomem_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            rdy[k] = iomem_ready;
            if (iomem_ready && iomem_rdata !== 32'h0400_0000)
                data_ok = 1'b0;
        end
        iomem_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (rdy !== 6'b010101 || data_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b: ready %b data_ok %b exp 010101 1",
                     rdy, data_ok);
        end
    endtask

    task automatic test_reset_during_ack();
        iomem_addr  = 8'h0C;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'hDEAD_BEEF;
        iomem_valid = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (iomem_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ack_pre: rdy %b exp 1", iomem_ready);
        end
        resetn = 1'b0;
        #1;
        n_tests++;
        if (iomem_ready !== 1'b0 || sprite_config[127:96] !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_ack_now: rdy %b cfg %h exp 0 0",
                     iomem_ready, sprite_config[127:96]);
        end
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
        bus_xfer(8'h0C, 4'h0, 32'h0, rd, cyc);
        n_tests++;
        if (rd !== 32'h0 || cyc !== 1) begin
            n_fail++;
            $display("FAIL rst_ack_lost: got %h cyc %0d exp 0 1", rd, cyc);
        end
        bus_xfer(8'h08, 4'h0, 32'h0, rd, cyc);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_ack_w2: got %h exp 0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_byte_strobes();
        test_out_of_range();
        test_config_commit();
        test_pixel_pipeline();
        test_collision();
        test_back_to_back();
        test_reset_during_ack();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
